pixel_fifo: RTL
===============

Name: pixel_fifo

Overview:
- Plot-request buffer between the draw multiplexer and the VGA adapter.
- Accepts at most one (x, y, colour) plot per cycle from the draw multiplexer and stores it in a circular buffer.
- Forwards stored plots to the VGA adapter in order, one per cycle, whenever the adapter signals ready.
- Decouples the draw FSMs from adapter stalls; reports fill level, drops and overflow.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth (default 16 entries).
- SCREEN_W, 160, screen width in pixels (clip bound).
- SCREEN_H, 120, screen height in pixels (clip bound).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- in_x  input  10  plot x from the draw multiplexer.
- in_y  input  10  plot y from the draw multiplexer.
- in_colour  input  3  plot colour.
- in_write  input  1  plot request valid this cycle.
- out_ready  input  1  VGA adapter can take a plot this cycle.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.
- out_x  output  8  x to the adapter (in_x[7:0]).
- out_y  output  7  y to the adapter (in_y[6:0]).
- out_colour  output  3  colour to the adapter.
- out_plot  output  1  plot strobe to the adapter.
- level  output  DEPTH_LOG2+1  current entry count.
- full  output  1  level == 2^DEPTH_LOG2.
- empty  output  1  level == 0.
- overflow  output  1  sticky flag: a request was dropped.
- drop_count  output  16  saturating count of dropped requests.

Behaviour:
- Reset (async, active-high): rd/wr pointers=0, level=0, empty=1, full=0, overflow=0, drop_count=0, out_plot=0. Buffer contents are don't-care.
- Storage: 2^DEPTH_LOG2 entries of {x[7:0], y[6:0], colour[2:0]} (18 bits). Upper in_x/in_y bits are discarded at write.
- Show-ahead read:
  - out_x/out_y/out_colour always reflect the entry at rd_ptr.
  - out_plot = ~empty & out_ready, combinational.
  - A pop occurs on every cycle with out_plot=1; rd_ptr then increments at the clock edge.
- Push: accepted when in_write & (~full | pop). wr_ptr increments at the clock edge.
- Latency: a plot written into an empty FIFO appears on out_* the following cycle. out_plot asserts that cycle if out_ready=1.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- level update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both occur; level stays at max; no drop.
  - When empty: no pop (out_plot=0); push occurs.
- Drop: in_write & full & ~pop. The request is discarded and the FIFO is unchanged. overflow<=1 and drop_count increments, saturating at 16'hFFFF.
- clear_overflow: overflow<=0 and drop_count<=0 next edge. If a drop happens the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset asserted mid-stream clears all state immediately. out_plot drops to 0 combinationally because empty=1.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro PIXEL_FIFO_CLIP_EN.
- Defined: a request with in_x >= SCREEN_W or in_y >= SCREEN_H is silently discarded at input. It is not stored, not counted as a drop and does not set overflow, even when the FIFO is full.
- Undefined: every request is treated identically and truncated to 8/7 bits as above.

Test Plan:
- Reset then idle, out_ready=1 -> empty=1, level=0, out_plot=0, overflow=0, drop_count=0.
- Write (x=5,y=7,c=3'b101) with out_ready=1 -> next cycle out_plot=1 with out_x=5, out_y=7, out_colour=5. Following cycle empty=1.
- out_ready=0, write 16 plots x=0..15 -> full=1, level=16. Write a 17th -> overflow=1, drop_count=1, level=16. Then out_ready=1 -> outputs x=0..15 in order over 16 consecutive cycles, then empty.
- Full FIFO, in_write=1 and out_ready=1 for 20 cycles with x incrementing -> no drops, level stays 16, output order preserved across pointer wrap.
- drop_count at 16'hFFFE plus 3 further drops -> holds 16'hFFFF. Pulse clear_overflow -> overflow=0, drop_count=0. clear_overflow coincident with a drop -> overflow=1, drop_count=1.
- Clip: PIXEL_FIFO_CLIP_EN defined, write x=160,y=10 then x=159,y=119 -> only the second is output; drop_count unchanged. Undefined: both are output, the first as out_x=160[7:0]=160.

Source files
------------

// File: rtl/pixel_fifo.sv
// pixel_fifo: plot-request buffer between the draw multiplexer and the VGA adapter.
// Latency: a plot written into an empty buffer is presented on out_* the next cycle.
// Backpressure: out_ready stalls the output side; writes that arrive while full and not popping are dropped.
//
// Ports:
//   clk, reset                      system clock, asynchronous active-high reset
//   in_x/in_y/in_colour/in_write    plot request from the draw multiplexer
//   out_ready                       adapter can take a plot this cycle
//   clear_overflow                  synchronous clear of overflow and drop_count
//   out_x/out_y/out_colour/out_plot show-ahead head entry and plot strobe to the adapter
//   level/full/empty                fill status
//   overflow/drop_count             sticky drop flag and saturating drop counter
//
// Build option: define PIXEL_FIFO_CLIP_EN to silently discard off-screen
// requests (x >= SCREEN_W or y >= SCREEN_H) before they reach the buffer.
module pixel_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            in_x,
  input  logic [9:0]            in_y,
  input  logic [2:0]            in_colour,
  input  logic                  in_write,
  input  logic                  out_ready,
  input  logic                  clear_overflow,
  output logic [7:0]            out_x,
  output logic [6:0]            out_y,
  output logic [2:0]            out_colour,
  output logic                  out_plot,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [9:0] X_LIM = 10'(SCREEN_W);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_t;

  pix_t                  mem [DEPTH];
  pix_t                  head;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  in_range;
  logic                  req;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign in_range = (in_x < X_LIM) & (in_y < Y_LIM);

`ifdef PIXEL_FIFO_CLIP_EN
  // Off-screen requests vanish here, so they can never count as drops.
  assign req = in_write & in_range;
`else
  assign req = in_write;
  logic unused_in_range;
  assign unused_in_range = in_range;
`endif

  assign empty = (level == '0);
  assign full  = (level == LEVEL_MAX);

  // Pop is purely a function of registered state and out_ready, so there is
  // no combinational path from in_* to the output side.
  assign pop      = ~empty & out_ready;
  assign out_plot = pop;

  // When full, a simultaneous pop frees the slot being written this edge.
  assign push = req & (~full | pop);
  assign drop = req & full & ~pop;

  // Show-ahead: the head entry is always visible on the outputs.
  assign head       = mem[rd_ptr];
  assign out_x      = head.x;
  assign out_y      = head.y;
  assign out_colour = head.colour;

  // Storage needs no reset; only entries between the pointers are ever read as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)
        drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
